// File: rtl/stoch_encoder_multi_if.sv
// stoch_encoder_multi_if: frame handshake and pulse bus for the multi-channel stochastic encoder
interface stoch_encoder_multi_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    logic                      start;
    logic                      mode;
    logic [CHANNELS*WIDTH-1:0] value_in;
    logic                      ready;
    logic                      busy;
    logic [CHANNELS-1:0]       pulse_out;
    logic                      pulse_valid;
    logic                      frame_done;

    modport master (
        output start, mode, value_in,
        input  ready, busy, pulse_out, pulse_valid, frame_done
    );

    modport slave (
        input  start, mode, value_in,
        output ready, busy, pulse_out, pulse_valid, frame_done
    );
endinterface

// File: rtl/stoch_encoder_multi.sv
// stoch_encoder_multi: framed binary-to-stochastic encoder, one Fibonacci LFSR per channel
module stoch_encoder_multi #(
    parameter int          WIDTH      = 16,
    parameter int          CHANNELS   = 4,
    parameter int          STREAM_LEN = 256,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input logic                 clk,
    input logic                 rst,
    stoch_encoder_multi_if.slave bus
);
    localparam int CW = $clog2(STREAM_LEN + 1);
    localparam int T0 = WIDTH - 1;
    localparam int T1 = (WIDTH == 8) ? 5 : 13;
    localparam int T2 = (WIDTH == 8) ? 4 : 12;
    localparam int T3 = (WIDTH == 8) ? 3 : 10;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                mode_q;
    logic [WIDTH-1:0]    val [CHANNELS];
    logic [WIDTH-1:0]    lfsr [CHANNELS];
    logic [CHANNELS-1:0] pulse;
    logic                valid;
    logic                done;

    // Channel seeds are offset so channels with equal values still decorrelate
    function automatic logic [WIDTH-1:0] seed_of(int c);
        logic [31:0] t;
        t = 32'(SEED) + 32'(29 * c);
        return (t[WIDTH-1:0] == '0) ? WIDTH'(1) : t[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] step(logic [WIDTH-1:0] l);
        return {l[WIDTH-2:0], l[T0] ^ l[T1] ^ l[T2] ^ l[T3]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= 1'b0;
            pulse  <= '0;
            valid  <= 1'b0;
            done   <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                lfsr[c] <= seed_of(c);
                val[c]  <= '0;
            end
        end else begin
            pulse <= '0;
            valid <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state  <= RUN;
                    cnt    <= '0;
                    mode_q <= bus.mode;
                    for (int c = 0; c < CHANNELS; c++) begin
                        val[c]  <= bus.value_in[c*WIDTH +: WIDTH];
                        lfsr[c] <= seed_of(c);
                    end
                end
                RUN: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        pulse[c] <= mode_q ? (val[c] >= lfsr[c]) : (val[c] > lfsr[c]);
                        lfsr[c]  <= step(lfsr[c]);
                    end
                    valid <= 1'b1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(STREAM_LEN - 1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready       = (state == IDLE);
    assign bus.busy        = (state == RUN);
    assign bus.pulse_out   = pulse;
    assign bus.pulse_valid = valid;
    assign bus.frame_done  = done;
endmodule

// File: tb/tb_stoch_encoder_multi.sv
// tb_stoch_encoder_multi: cycle scoreboard plus full-period count, repeatability and handshake checks
module tb_stoch_encoder_multi;
    localparam int W  = 8;
    localparam int CH = 4;
    localparam int L  = 255;
    localparam logic [31:0] V = 32'hFF80_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stoch_encoder_multi_if #(.WIDTH(W), .CHANNELS(CH)) bus ();
    stoch_encoder_multi #(.WIDTH(W), .CHANNELS(CH), .STREAM_LEN(L), .SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_chk = 0, n_pass = 0, cyc = 0, done_cnt = 0, d0 = 0;
    logic [7:0]    exp_q [$];
    logic [CH-1:0] cap [$];
    logic [CH-1:0] ref1 [$];
    int            done_t [$];

    logic          m_run = 1'b0;
    int            m_cnt = 0;
    logic          m_mode = 1'b0;
    logic [W-1:0]  m_val [CH];
    logic [W-1:0]  m_lfsr [CH];
    logic [CH-1:0] m_p;
    logic          m_v, m_d;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] seed(int c);
        logic [31:0] t;
        t = 32'hACE1 + 32'(29 * c);
        return (t[7:0] == 8'd0) ? 8'd1 : t[7:0];
    endfunction

    function automatic logic [7:0] nxt(logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    function automatic int ones(int c);
        int n;
        n = 0;
        foreach (cap[i]) n += int'(cap[i][c]);
        return n;
    endfunction

    function automatic int diff_ref();
        int n;
        n = 0;
        foreach (cap[i]) if (i >= ref1.size() || cap[i] !== ref1[i]) n++;
        return n;
    endfunction

    function automatic int diff_ch01();
        int n;
        n = 0;
        foreach (cap[i]) if (cap[i][0] != cap[i][1]) n++;
        return n;
    endfunction

    // Reference model: expected outputs after each rising edge
    initial forever begin
        @(posedge clk);
        m_p = '0;
        m_v = 1'b0;
        m_d = 1'b0;
        if (rst) m_run = 1'b0;
        else if (!m_run) begin
            if (bus.start) begin
                m_run  = 1'b1;
                m_cnt  = 0;
                m_mode = bus.mode;
                for (int c = 0; c < CH; c++) begin
                    m_val[c]  = bus.value_in[c*W +: W];
                    m_lfsr[c] = seed(c);
                end
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                m_p[c]    = m_mode ? (m_val[c] >= m_lfsr[c]) : (m_val[c] > m_lfsr[c]);
                m_lfsr[c] = nxt(m_lfsr[c]);
            end
            m_v = 1'b1;
            m_cnt++;
            if (m_cnt == L) begin
                m_run = 1'b0;
                m_d   = 1'b1;
            end
        end
        exp_q.push_back({~m_run, m_run, m_d, m_v, m_p});
    end

    initial forever begin
        @(negedge clk);
        cyc++;
        if (exp_q.size() == 0) check("sb_empty", 0, 1);
        else check("cycle", {bus.ready, bus.busy, bus.frame_done, bus.pulse_valid, bus.pulse_out}, exp_q.pop_front());
        if (bus.pulse_valid) cap.push_back(bus.pulse_out);
        if (bus.frame_done) begin
            done_cnt++;
            done_t.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_frame(logic [31:0] v, logic md);
        cap.delete();
        d0 = done_cnt;
        bus.value_in = v;
        bus.mode     = md;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(int target);
        for (int i = 0; i < 2000 && done_cnt < target; i++) tick();
        if (done_cnt < target) check("timeout", done_cnt, target);
    endtask

    task automatic finish_frame(string tag);
        wait_done(d0 + 1);
        repeat (3) tick();
        check({tag, "_len"}, cap.size(), L);
        check({tag, "_done"}, done_cnt - d0, 1);
    endtask

    initial begin
        bus.start    = 1'b1;
        bus.mode     = 1'b0;
        bus.value_in = '0;
        repeat (2) tick();
        check("rst_no_start", {bus.busy, bus.pulse_valid}, 0);
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();
        check("rst_ready", bus.ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_pulse", {bus.frame_done, bus.pulse_valid, bus.pulse_out}, 0);

        start_frame(V, 1'b0);
        finish_frame("m0");
        check("m0_c0", ones(0), 0);
        check("m0_c1", ones(1), 0);
        check("m0_c2", ones(2), 127);
        check("m0_c3", ones(3), 254);

        start_frame(V, 1'b1);
        finish_frame("m1");
        check("m1_c0", ones(0), 0);
        check("m1_c1", ones(1), 1);
        check("m1_c2", ones(2), 128);
        check("m1_c3", ones(3), 255);
        ref1 = cap;

        start_frame(V, 1'b1);
        finish_frame("rep");
        check("rep_diff", diff_ref(), 0);

        start_frame(32'h8080_8080, 1'b0);
        finish_frame("dec");
        check("decor", diff_ch01() != 0, 1);

        start_frame(V, 1'b1);
        repeat (50) tick();
        bus.start    = 1'b1;
        bus.value_in = '0;
        tick();
        bus.start = 1'b0;
        finish_frame("mid_start");
        check("mid_start_diff", diff_ref(), 0);

        start_frame(V, 1'b0);
        repeat (10) tick();
        bus.value_in = $urandom;
        bus.mode     = 1'b1;
        finish_frame("chg");
        check("chg_c1", ones(1), 0);
        check("chg_c2", ones(2), 127);
        check("chg_c3", ones(3), 254);

        d0           = done_cnt;
        bus.value_in = V;
        bus.mode     = 1'b1;
        bus.start    = 1'b1;
        wait_done(d0 + 2);
        bus.start = 1'b0;
        if (done_t.size() >= 2)
            check("b2b_space", done_t[done_t.size()-1] - done_t[done_t.size()-2], L + 1);
        repeat (3) tick();
        check("b2b_idle", {bus.ready, bus.busy}, 2'b10);

        start_frame(V, 1'b1);
        for (int i = 0; i < 400 && cap.size() < 100; i++) tick();
        rst = 1'b1;
        tick();
        check("rmid_state", {bus.pulse_valid, bus.ready}, 2'b01);
        check("rmid_bits", cap.size(), 100);
        rst = 1'b0;
        repeat (300) tick();
        check("rmid_nodone", done_cnt - d0, 0);
        start_frame(V, 1'b1);
        finish_frame("rmid_after");
        check("rmid_diff", diff_ref(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
